// File: rtl/seq_controller_pkg.sv
// seq_ctrl_pkg: opcodes, sequencer states and beat-count helper shared by seq_controller and its bench
// Exports: OP_* opcode values, state_t, beats_for_op()
package seq_ctrl_pkg;

    localparam int unsigned OP_NOP           = 0;
    localparam int unsigned OP_SET_ACT_DENSE = 1;
    localparam int unsigned OP_SET_COST      = 2;
    localparam int unsigned OP_LOAD_WEIGHT   = 3;
    localparam int unsigned OP_LOAD_INPUT    = 4;
    localparam int unsigned OP_SET_LR        = 5;
    localparam int unsigned OP_UPDATE        = 6;
    localparam int unsigned OP_STALL         = 7;
    localparam int unsigned OP_LOAD_Z        = 8;
    localparam int unsigned OP_HALT          = 9;

    typedef enum logic [1:0] {IDLE, EXEC, WAIT_TRAIN, HALT} state_t;

    function automatic int unsigned beats_for_op(input int unsigned op, input int unsigned param_c,
                                                 input int unsigned size);
        return (op == OP_LOAD_WEIGHT || op == OP_LOAD_INPUT || op == OP_LOAD_Z) ? size :
               (op == OP_STALL && param_c != 0) ? param_c : 1;
    endfunction

endpackage

// File: rtl/seq_controller_beat_counter.sv
// beat_counter: per-op beat index with clear, enable and terminal-count compare
// Ports: clk, reset (sync, active-high), i_clr, i_en, i_term (last index) -> o_count, o_last
module beat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_term,
    output logic [W-1:0] o_count,
    output logic         o_last
);

    logic [W-1:0] r_count;

    // Saturates at the terminal count so a frozen or finished op never wraps.
    always_ff @(posedge clk)
        if (reset || i_clr) r_count <= '0;
        else if (i_en && !o_last) r_count <= r_count + 1'b1;

    assign o_count = r_count;
    assign o_last  = r_count == i_term;

endmodule

// File: rtl/seq_controller.sv
// seq_controller: fetches opcodes over valid/ready and sequences multi-beat loads and config strobes
// Ports: clk, reset, enable, instr_valid/instr_ready, op, param_a, param_b, train_done in;
//        load/store/config strobes with layer/row indices, busy, halted, illegal_op out.
// Macro SEQ_CTRL_TRAIN_WAIT_EN: update_weight waits in WAIT_TRAIN for train_done.
module seq_controller
    import seq_ctrl_pkg::*;
#(
    parameter int SIZE         = 3,
    parameter int OP_SIZE      = 4,
    parameter int PARAM_A_SIZE = 4,
    parameter int PARAM_B_SIZE = 4,
    parameter int IDX_W        = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic [OP_SIZE-1:0]      op,
    input  logic [PARAM_A_SIZE-1:0] param_a,
    input  logic [PARAM_B_SIZE-1:0] param_b,
    input  logic                    train_done,
    output logic [IDX_W-1:0]        w_layer_index,
    output logic [IDX_W-1:0]        w_row_index,
    output logic                    is_load,
    output logic                    i_is_load,
    output logic                    load_w,
    output logic                    use_z,
    output logic                    is_store,
    output logic                    start_train,
    output logic [IDX_W-1:0]        bp_layer,
    output logic [IDX_W-1:0]        bp_row,
    output logic                    set_act_type,
    output logic                    set_dense_type,
    output logic                    set_cost_type,
    output logic                    set_learning_rate_value,
    output logic                    busy,
    output logic                    halted,
    output logic                    illegal_op
);

    localparam int PC_W = PARAM_A_SIZE + PARAM_B_SIZE;
    localparam int CW   = ($clog2(SIZE) > PC_W) ? $clog2(SIZE) : PC_W;
`ifdef SEQ_CTRL_TRAIN_WAIT_EN
    localparam logic TRAIN_WAIT = 1'b1;
`else
    localparam logic TRAIN_WAIT = 1'b0;
`endif

    state_t             r_state;
    logic [OP_SIZE-1:0] r_op;
    logic [PC_W-1:0]    r_pc;
    logic               r_illegal;
    logic [CW-1:0]      w_count;
    logic               w_last, w_hold, w_accept, w_run, w_ld, w_st;
    logic [31:0]        w_op;

    assign w_op   = 32'(r_op);
    assign w_run  = enable && r_state == EXEC;
    // Ops whose last beat does not free the sequencer for a new instruction.
    assign w_hold = w_op == OP_HALT || (TRAIN_WAIT && w_op == OP_UPDATE);
    assign instr_ready = enable && (r_state == IDLE || (r_state == EXEC && w_last && !w_hold) ||
                                    (r_state == WAIT_TRAIN && train_done));
    assign w_accept = instr_valid && instr_ready;

    beat_counter #(.W(CW)) u_beat (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_accept),
        .i_en   (w_run),
        .i_term (CW'(beats_for_op(w_op, 32'(r_pc), SIZE) - 1)),
        .o_count(w_count),
        .o_last (w_last)
    );

    always_ff @(posedge clk)
        if (reset) begin
            r_state   <= IDLE;
            r_op      <= '0;
            r_pc      <= '0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_state   <= EXEC;
            r_op      <= op;
            r_pc      <= {param_a, param_b};
            r_illegal <= r_illegal || 32'(op) > OP_HALT;
        end else if (enable) begin
            if (r_state == EXEC && w_last)
                r_state <= (w_op == OP_HALT) ? HALT : w_hold ? WAIT_TRAIN : IDLE;
            else if (r_state == WAIT_TRAIN && train_done)
                r_state <= IDLE;
        end

    assign w_ld = w_run && (w_op == OP_LOAD_WEIGHT || w_op == OP_LOAD_INPUT || w_op == OP_LOAD_Z);
    assign w_st = w_run && (w_op == OP_LOAD_INPUT || w_op == OP_LOAD_Z);

    assign is_load                 = w_ld;
    assign load_w                  = w_run && w_op == OP_LOAD_WEIGHT;
    assign i_is_load               = w_run && w_op == OP_LOAD_INPUT;
    assign use_z                   = w_run && w_op == OP_LOAD_Z;
    assign is_store                = w_st;
    assign start_train             = w_run && w_op == OP_UPDATE;
    assign set_act_type            = w_run && w_op == OP_SET_ACT_DENSE;
    assign set_dense_type          = w_run && w_op == OP_SET_ACT_DENSE;
    assign set_cost_type           = w_run && w_op == OP_SET_COST;
    assign set_learning_rate_value = w_run && w_op == OP_SET_LR;
    assign w_layer_index           = w_ld ? IDX_W'(r_pc) : '0;
    assign w_row_index             = w_ld ? IDX_W'(w_count) : '0;
    assign bp_layer                = w_st ? IDX_W'(r_pc) : '0;
    assign bp_row                  = w_st ? IDX_W'(w_count) : '0;
    assign busy                    = r_state != IDLE;
    assign halted                  = r_state == HALT;
    assign illegal_op              = r_illegal;

endmodule

// File: tb/tb_seq_controller.sv
// tb_seq_controller: cycle-by-cycle scoreboard bench for seq_controller
module tb_seq_controller;

    logic        clk = 1'b0, reset = 1'b1, enable = 1'b1, instr_valid = 1'b0, train_done = 1'b0;
    logic [3:0]  op = '0, param_a = '0, param_b = '0;
    logic        instr_ready, is_load, i_is_load, load_w, use_z, is_store, start_train;
    logic        set_act_type, set_dense_type, set_cost_type, set_learning_rate_value;
    logic        busy, halted, illegal_op;
    logic [31:0] w_layer_index, w_row_index, bp_layer, bp_row;

    seq_controller dut (
        .clk(clk), .reset(reset), .enable(enable), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .op(op), .param_a(param_a), .param_b(param_b),
        .train_done(train_done), .w_layer_index(w_layer_index), .w_row_index(w_row_index),
        .is_load(is_load), .i_is_load(i_is_load), .load_w(load_w), .use_z(use_z),
        .is_store(is_store), .start_train(start_train), .bp_layer(bp_layer), .bp_row(bp_row),
        .set_act_type(set_act_type), .set_dense_type(set_dense_type),
        .set_cost_type(set_cost_type), .set_learning_rate_value(set_learning_rate_value),
        .busy(busy), .halted(halted), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic rst, en, v, td; logic [3:0] op; logic [7:0] pc;} stim_t;
    typedef struct packed {logic rdy, bsy, hlt, ill; logic [9:0] stb; logic [7:0] lay, row, bl, br;} obs_t;

    // Strobe order: is_load, i_is_load, load_w, use_z, is_store, start_train, act, dense, cost, lr
    localparam logic [9:0] N  = 10'b0000000000;
    localparam logic [9:0] LW = 10'b1010000000;
    localparam logic [9:0] LI = 10'b1100100000;
    localparam logic [9:0] LZ = 10'b1001100000;
    localparam logic [9:0] ST = 10'b0000010000;
    localparam logic [9:0] AD = 10'b0000001100;
    localparam logic [9:0] CO = 10'b0000000010;

    stim_t st_q[$];
    obs_t  exp_q[$];
    int    total = 0, passed = 0;

    function automatic stim_t s(input int rst, en, v, td, o, pc);
        return {1'(rst), 1'(en), 1'(v), 1'(td), 4'(o), 8'(pc)};
    endfunction

    function automatic obs_t x(input int rdy, bsy, hlt, ill, input logic [9:0] stb, input int lay, row, bl, br);
        return {1'(rdy), 1'(bsy), 1'(hlt), 1'(ill), stb, 8'(lay), 8'(row), 8'(bl), 8'(br)};
    endfunction

    function automatic obs_t sample();
        return {instr_ready, busy, halted, illegal_op,
                is_load, i_is_load, load_w, use_z, is_store, start_train,
                set_act_type, set_dense_type, set_cost_type, set_learning_rate_value,
                w_layer_index[7:0], w_row_index[7:0], bp_layer[7:0], bp_row[7:0]};
    endfunction

    task automatic push(input stim_t st, input obs_t e);
        st_q.push_back(st);
        exp_q.push_back(e);
    endtask

    task automatic apply(input stim_t st);
        reset = st.rst;
        enable = st.en;
        instr_valid = st.v;
        train_done = st.td;
        op = st.op;
        {param_a, param_b} = st.pc;
    endtask

    task automatic test_reset();
        stim_t st;
        obs_t e, o;
        push(s(0,1,0,0,0,0), x(1,0,0,0,N,0,0,0,0));
        push(s(0,0,0,0,0,0), x(0,0,0,0,N,0,0,0,0));
        for (int k = 0; st_q.size() > 0; k++) begin
            st = st_q.pop_front(); apply(st); #3;
            e = exp_q.pop_front(); o = sample(); total++;
            if (o === e) passed++; else $display("FAIL reset cyc%0d got=%h exp=%h", k, o, e);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        stim_t st;
        obs_t e, o;
        push(s(0,1,1,0,3,5), x(1,0,0,0,N,0,0,0,0));
        push(s(0,1,1,0,2,0), x(0,1,0,0,LW,5,0,0,0));
        push(s(0,1,1,0,2,0), x(0,1,0,0,LW,5,1,0,0));
        push(s(0,1,1,0,2,0), x(1,1,0,0,LW,5,2,0,0));
        push(s(0,1,0,0,0,0), x(1,1,0,0,CO,0,0,0,0));
        push(s(0,1,0,0,0,0), x(1,0,0,0,N,0,0,0,0));
        for (int k = 0; st_q.size() > 0; k++) begin
            st = st_q.pop_front(); apply(st); #3;
            e = exp_q.pop_front(); o = sample(); total++;
            if (o === e) passed++; else $display("FAIL back_to_back cyc%0d got=%h exp=%h", k, o, e);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        stim_t st;
        obs_t e, o;
        push(s(0,1,1,0,7,4), x(1,0,0,0,N,0,0,0,0));
        for (int i = 0; i < 3; i++) push(s(0,1,0,0,0,0), x(0,1,0,0,N,0,0,0,0));
        push(s(0,1,0,0,0,0), x(1,1,0,0,N,0,0,0,0));
        push(s(0,1,1,0,7,0), x(1,0,0,0,N,0,0,0,0));
        push(s(0,1,0,0,0,0), x(1,1,0,0,N,0,0,0,0));
        push(s(0,1,0,0,0,0), x(1,0,0,0,N,0,0,0,0));
        for (int k = 0; st_q.size() > 0; k++) begin
            st = st_q.pop_front(); apply(st); #3;
            e = exp_q.pop_front(); o = sample(); total++;
            if (o === e) passed++; else $display("FAIL stall cyc%0d got=%h exp=%h", k, o, e);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_enable_freeze();
        stim_t st;
        obs_t e, o;
        push(s(0,1,1,0,8,2), x(1,0,0,0,N,0,0,0,0));
        push(s(0,1,0,0,0,0), x(0,1,0,0,LZ,2,0,2,0));
        for (int i = 0; i < 3; i++) push(s(0,0,0,0,0,0), x(0,1,0,0,N,0,0,0,0));
        push(s(0,1,0,0,0,0), x(0,1,0,0,LZ,2,1,2,1));
        push(s(0,1,0,0,0,0), x(1,1,0,0,LZ,2,2,2,2));
        push(s(0,1,0,0,0,0), x(1,0,0,0,N,0,0,0,0));
        for (int k = 0; st_q.size() > 0; k++) begin
            st = st_q.pop_front(); apply(st); #3;
            e = exp_q.pop_front(); o = sample(); total++;
            if (o === e) passed++; else $display("FAIL enable_freeze cyc%0d got=%h exp=%h", k, o, e);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_update();
        stim_t st;
        obs_t e, o;
        push(s(0,1,1,0,6,0), x(1,0,0,0,N,0,0,0,0));
`ifdef SEQ_CTRL_TRAIN_WAIT_EN
        push(s(0,1,0,1,0,0), x(0,1,0,0,ST,0,0,0,0));
        for (int i = 0; i < 4; i++) push(s(0,1,0,0,0,0), x(0,1,0,0,N,0,0,0,0));
        push(s(0,1,1,1,1,0), x(1,1,0,0,N,0,0,0,0));
`else
        push(s(0,1,0,1,0,0), x(1,1,0,0,ST,0,0,0,0));
        push(s(0,1,1,0,1,0), x(1,0,0,0,N,0,0,0,0));
`endif
        push(s(0,1,0,0,0,0), x(1,1,0,0,AD,0,0,0,0));
        push(s(0,1,0,0,0,0), x(1,0,0,0,N,0,0,0,0));
        for (int k = 0; st_q.size() > 0; k++) begin
            st = st_q.pop_front(); apply(st); #3;
            e = exp_q.pop_front(); o = sample(); total++;
            if (o === e) passed++; else $display("FAIL update cyc%0d got=%h exp=%h", k, o, e);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal_halt();
        stim_t st;
        obs_t e, o;
        push(s(0,1,1,0,12,0), x(1,0,0,0,N,0,0,0,0));
        push(s(0,1,0,0,0,0), x(1,1,0,1,N,0,0,0,0));
        push(s(0,1,1,0,9,0), x(1,0,0,1,N,0,0,0,0));
        push(s(0,1,1,0,2,0), x(0,1,0,1,N,0,0,0,0));
        for (int i = 0; i < 4; i++) push(s(0,1,1,0,2,0), x(0,1,1,1,N,0,0,0,0));
        for (int k = 0; st_q.size() > 0; k++) begin
            st = st_q.pop_front(); apply(st); #3;
            e = exp_q.pop_front(); o = sample(); total++;
            if (o === e) passed++; else $display("FAIL illegal_halt cyc%0d got=%h exp=%h", k, o, e);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_midop();
        stim_t st;
        obs_t e, o;
        push(s(1,1,0,0,0,0), x(0,1,1,1,N,0,0,0,0));
        push(s(0,1,1,0,4,3), x(1,0,0,0,N,0,0,0,0));
        push(s(0,1,0,0,0,0), x(0,1,0,0,LI,3,0,3,0));
        push(s(1,1,0,0,0,0), x(0,1,0,0,LI,3,1,3,1));
        push(s(0,1,0,0,0,0), x(1,0,0,0,N,0,0,0,0));
        for (int k = 0; st_q.size() > 0; k++) begin
            st = st_q.pop_front(); apply(st); #3;
            e = exp_q.pop_front(); o = sample(); total++;
            if (o === e) passed++; else $display("FAIL reset_midop cyc%0d got=%h exp=%h", k, o, e);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_back_to_back();
        test_stall();
        test_enable_freeze();
        test_update();
        test_illegal_halt();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
